camera_bayer_demosaic: RTL and testbench
========================================

# camera_bayer_demosaic

Converts the raw 10-bit Bayer stream from the camera capture stage into 10-bit RGB pixels for the SDRAM write FIFOs, using 2x2 binning. Each 2x2 quad (GRBG) yields one RGB pixel, so a 1280x960 raw frame becomes a 640x480 RGB frame. The block sits between raw pixel capture and the SDRAM write port in the Clock domain. Its `oData_valid` output drives the SDRAM write enable.

## Interface
- LINE_WIDTH, 1280, maximum raw pixels per line stored; must be even
- ADDR_W, $clog2(LINE_WIDTH), line-buffer address width
- Clock  in  1  system clock, 50 MHz
- Resetn  in  1  asynchronous, active-low reset
- Enable  in  1  level; low aborts capture at the next accepted-pixel boundary
- iData  in  10  raw Bayer sample
- iData_valid  in  1  one-cycle strobe per raw sample, synchronous to Clock
- iFrame_valid  in  1  frame-active level
- iLine_valid  in  1  line-active level
- oRed, oGreen, oBlue  out  10 each  binned RGB pixel
- oData_valid  out  1  one-cycle strobe per RGB pixel
- oFrame_count  out  32  completed frames

## Operation
- Accepted pixel: `iData_valid & iFrame_valid & iLine_valid` while in ACTIVE.
- State machine:
  - IDLE: leave to WAIT_FRAME when Enable = 1.
  - WAIT_FRAME: wait for a rising edge of iFrame_valid, then go to ACTIVE with row parity 0 and column 0.
  - ACTIVE: on a falling edge of iFrame_valid, increment oFrame_count and go to WAIT_FRAME. If Enable = 0 in any state, go to IDLE; an in-progress frame is discarded and not counted.
- Edges of iFrame_valid and iLine_valid are detected against 1-cycle registered copies.
- Column counter (ADDR_W+1 bits):
  - Increments per accepted pixel and clears on a falling edge of iLine_valid.
  - Pixels with column >= LINE_WIDTH are ignored and the counter saturates.
- Row parity toggles on each iLine_valid falling edge that had at least one accepted pixel. Empty lines do not toggle it.
- Even row (G1 R G1 R ...):
  - Write each accepted pixel into the line buffer at address = column.
  - At line end, latch the pixel count into `even_len`.
- Odd row (B G2 B G2 ...):
  - Hold the B sample (even column) in a register.
  - On the G2 sample (odd column c), read buffer entries c-1 (G1) and c (R).
  - Emit R = buf[c], B = held, G = (G1 + G2) >> 1 using an 11-bit sum, bits [10:1].
  - Emit only if c < even_len. Otherwise no output.
- A trailing unpaired pixel (odd line length) produces no output.
- If the frame ends after an even row, no output is produced for that row.
- The line buffer is not cleared between frames. `even_len` clears to 0 on frame start.

## Timing
- Reset values:
  - state IDLE, parity 0, column 0, even_len 0
  - oRed, oGreen, oBlue = 0
  - oData_valid = 0
  - oFrame_count = 0
- Latency: oData_valid pulses exactly 2 cycles after the accepting cycle of the odd-column pixel on an odd row. The cycle sequence is: buffer read issued, synchronous RAM data, registered output.
- RGB outputs hold their value until the next oData_valid.
- Throughput: one accepted pixel per cycle sustained, with no stalls and no backpressure.
- A line buffer read and write at the same address never occur together, because reads happen only on odd rows.
- Simultaneous iLine_valid fall and iFrame_valid fall: line end is processed first, then the frame is counted; both take effect in the same cycle.
- A Resetn assertion mid-frame clears everything immediately. Capture restarts only at the next frame-start edge.

## Configuration
- `DEMOSAIC_FRAME_COUNT_EN`
  - Defined: oFrame_count operates as above.
  - Undefined: oFrame_count is tied to 0 and the counter logic is removed. All other behaviour is unchanged.

## Structure
- Package `demosaic_pkg` contains:
  - state enum `demosaic_state_t` {IDLE, WAIT_FRAME, ACTIVE}
  - `PIX_W = 10`
  - Bayer position constants for GRBG
- Sub-module `demosaic_line_buffer`: simple dual-port RAM, LINE_WIDTH x 10, with 1-cycle registered read. It must infer block RAM.

## Test plan
- 4x2 frame, even row G1/R = 100, 200, 102, 202; odd row B/G2 = 300, 110, 302, 112 -> two pulses:
  - (R 200, G 105, B 300)
  - (R 202, G 107, B 302)
  - Each pulse arrives 2 cycles after its G2 sample.
- G1 = 1023, G2 = 1022 -> G = 1022, with no overflow.
- Even row of 2 pixels, odd row of 6 pixels -> only one output.
- Line of 5 pixels -> 2 outputs per row pair; the 5th pixel is ignored.
- Enable dropped mid-frame -> no further outputs, frame count unchanged, and recovery on the next frame after Enable returns to 1.
- Three full 1280x960 frames -> 3 x 307200 oData_valid pulses and oFrame_count = 3. The count is 0 when `DEMOSAIC_FRAME_COUNT_EN` is undefined.

Source files
------------

// File: rtl/camera_bayer_demosaic_pkg.sv
// Shared types and helpers for the GRBG 2x2-binning demosaic block.
package demosaic_pkg;

  localparam int PIX_W = 10;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    ACTIVE     = 2'd2
  } demosaic_state_t;

  // Bayer site addressed by {row parity, column lsb} for a GRBG mosaic
  localparam logic [1:0] BAYER_G1 = 2'b00;
  localparam logic [1:0] BAYER_R  = 2'b01;
  localparam logic [1:0] BAYER_B  = 2'b10;
  localparam logic [1:0] BAYER_G2 = 2'b11;

  function automatic logic [PIX_W-1:0] green_avg(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
    logic [PIX_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[PIX_W:1];
  endfunction

endpackage

// File: rtl/camera_bayer_demosaic_line_buffer.sv
// Simple dual-port line store with a registered read port; no reset so it maps onto block RAM.
module demosaic_line_buffer
  import demosaic_pkg::*;
#(
  parameter int DEPTH  = 1280,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data
);

  logic [PIX_W-1:0] mem_r [DEPTH];

  // Write port and one-cycle registered read port
  always_ff @(posedge Clock) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/camera_bayer_demosaic.sv
// Bayer GRBG to RGB via 2x2 binning: even rows fill the line buffer, odd rows pair against it.
// DEMOSAIC_FRAME_COUNT_EN enables the completed-frame counter on oFrame_count.
module camera_bayer_demosaic
  import demosaic_pkg::*;
#(
  parameter int LINE_WIDTH = 1280,
  parameter int ADDR_W     = $clog2(LINE_WIDTH)
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Enable,
  input  logic [PIX_W-1:0]  iData,
  input  logic              iData_valid,
  input  logic              iFrame_valid,
  input  logic              iLine_valid,
  output logic [PIX_W-1:0]  oRed,
  output logic [PIX_W-1:0]  oGreen,
  output logic [PIX_W-1:0]  oBlue,
  output logic              oData_valid,
  output logic [31:0]       oFrame_count
);

  localparam logic [ADDR_W:0] COL_MAX = (ADDR_W + 1)'(LINE_WIDTH);
  localparam logic [ADDR_W:0] COL_ONE = {{ADDR_W{1'b0}}, 1'b1};

  demosaic_state_t  state_r;
  demosaic_state_t  state_s;
  logic             frame_d_r;
  logic             line_d_r;
  logic             frame_rise_s;
  logic             frame_fall_s;
  logic             line_fall_s;
  logic             frame_start_s;
  logic             line_end_s;
  logic             take_s;
  logic [ADDR_W:0]  col_r;
  logic             parity_r;
  logic [ADDR_W:0]  even_len_r;
  logic [1:0]       bayer_pos_s;
  logic             wr_en_s;
  logic             rd_en_s;
  logic [PIX_W-1:0] rd_data_s;
  logic             g1_pend_r;
  logic             emit_pend_r;
  logic [PIX_W-1:0] b_hold_r;
  logic [PIX_W-1:0] g1_r;
  logic [PIX_W-1:0] g2_r;

  assign frame_rise_s  = iFrame_valid & ~frame_d_r;
  assign frame_fall_s  = ~iFrame_valid & frame_d_r;
  assign line_fall_s   = ~iLine_valid & line_d_r;
  assign frame_start_s = (state_r == WAIT_FRAME) & Enable & frame_rise_s;
  assign line_end_s    = (state_r == ACTIVE) & Enable & line_fall_s;
  // Pixels past the line buffer end are dropped; the column stays pinned at LINE_WIDTH
  assign take_s        = (state_r == ACTIVE) & Enable & iData_valid & iFrame_valid
                       & iLine_valid & (col_r < COL_MAX);
  assign bayer_pos_s   = {parity_r, col_r[0]};
  assign wr_en_s       = take_s & ~parity_r;
  assign rd_en_s       = take_s & parity_r;

  // Registered copies of the framing levels for edge detection
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      frame_d_r <= 1'b0;
      line_d_r  <= 1'b0;
    end else begin
      frame_d_r <= iFrame_valid;
      line_d_r  <= iLine_valid;
    end
  end

  // Capture state register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Capture state transitions; Enable low wins from every state
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (Enable) state_s = WAIT_FRAME;
        else        state_s = IDLE;
      end
      WAIT_FRAME: begin
        if (!Enable)           state_s = IDLE;
        else if (frame_rise_s) state_s = ACTIVE;
        else                   state_s = WAIT_FRAME;
      end
      ACTIVE: begin
        if (!Enable)           state_s = IDLE;
        else if (frame_fall_s) state_s = WAIT_FRAME;
        else                   state_s = ACTIVE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Column position, row parity and the length of the last even row
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      col_r      <= '0;
      parity_r   <= 1'b0;
      even_len_r <= '0;
    end else if (frame_start_s) begin
      col_r      <= '0;
      parity_r   <= 1'b0;
      even_len_r <= '0;
    end else if (line_end_s) begin
      col_r <= '0;
      if (col_r != '0) begin
        parity_r <= ~parity_r;
        if (!parity_r) begin
          even_len_r <= col_r;
        end
      end
    end else if (take_s) begin
      col_r <= col_r + COL_ONE;
    end
  end

  demosaic_line_buffer #(
    .DEPTH  (LINE_WIDTH),
    .ADDR_W (ADDR_W)
  ) u_line_buffer (
    .Clock   (Clock),
    .wr_en   (wr_en_s),
    .wr_addr (col_r[ADDR_W-1:0]),
    .wr_data (iData),
    .rd_en   (rd_en_s),
    .rd_addr (col_r[ADDR_W-1:0]),
    .rd_data (rd_data_s)
  );

  // Odd-row pairing: the B pixel fetches G1 from its column, the G2 pixel fetches R
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      g1_pend_r   <= 1'b0;
      emit_pend_r <= 1'b0;
      b_hold_r    <= '0;
      g1_r        <= '0;
      g2_r        <= '0;
    end else begin
      g1_pend_r   <= take_s & (bayer_pos_s == BAYER_B);
      emit_pend_r <= take_s & (bayer_pos_s == BAYER_G2) & (col_r < even_len_r);
      if (take_s & (bayer_pos_s == BAYER_B)) begin
        b_hold_r <= iData;
      end
      if (take_s & (bayer_pos_s == BAYER_G2)) begin
        g2_r <= iData;
      end
      if (g1_pend_r) begin
        g1_r <= rd_data_s;
      end
    end
  end

  // Registered RGB output; colour values hold between strobes
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      oData_valid <= 1'b0;
      oRed        <= '0;
      oGreen      <= '0;
      oBlue       <= '0;
    end else begin
      oData_valid <= emit_pend_r;
      if (emit_pend_r) begin
        oRed   <= rd_data_s;
        oGreen <= green_avg(g1_r, g2_r);
        oBlue  <= b_hold_r;
      end
    end
  end

`ifdef DEMOSAIC_FRAME_COUNT_EN
  logic        frame_done_s;
  logic [31:0] frame_count_r;

  assign frame_done_s = (state_r == ACTIVE) & Enable & frame_fall_s;

  // Completed-frame counter; aborted frames never reach the falling edge in ACTIVE
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      frame_count_r <= 32'd0;
    end else if (frame_done_s) begin
      frame_count_r <= frame_count_r + 32'd1;
    end
  end

  assign oFrame_count = frame_count_r;
`else
  assign oFrame_count = 32'd0;
`endif

endmodule

// File: tb/tb_camera_bayer_demosaic.sv
// Directed bench for camera_bayer_demosaic: table of single-quad frames plus multi-cycle sequences.
module tb_camera_bayer_demosaic;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Enable;
  logic [9:0] iData;
  logic       iData_valid;
  logic       iFrame_valid;
  logic       iLine_valid;
  logic [9:0] oRed, oGreen, oBlue;
  logic       oData_valid;
  logic [31:0] oFrame_count;

  camera_bayer_demosaic #(.LINE_WIDTH(8)) dut (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .Enable       (Enable),
    .iData        (iData),
    .iData_valid  (iData_valid),
    .iFrame_valid (iFrame_valid),
    .iLine_valid  (iLine_valid),
    .oRed         (oRed),
    .oGreen       (oGreen),
    .oBlue        (oBlue),
    .oData_valid  (oData_valid),
    .oFrame_count (oFrame_count)
  );

  always #10 Clock = ~Clock;

  typedef logic [9:0] line_t [16];
  typedef struct { int r; int g; int b; int cyc; } out_t;
  typedef struct { int g1; int r; int b; int g2; int er; int eg; int eb; } vec_t;

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    exp_frames = 0;
  int    acc [16];
  out_t  act_q [$];
  out_t  exp_q [$];
  vec_t  vecs [6];
  line_t ln;

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    if (oData_valid === 1'b1) act_q.push_back('{int'(oRed), int'(oGreen), int'(oBlue), cyc});
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  function automatic line_t mk6(input int a0 = 0, input int a1 = 0, input int a2 = 0,
                                input int a3 = 0, input int a4 = 0, input int a5 = 0);
    line_t l;
    for (int i = 0; i < 16; i++) l[i] = 10'd0;
    l[0] = 10'(a0); l[1] = 10'(a1); l[2] = 10'(a2);
    l[3] = 10'(a3); l[4] = 10'(a4); l[5] = 10'(a5);
    return l;
  endfunction

  task automatic frame_begin();
    iFrame_valid = 1'b1;
    tick(2);
  endtask

  // end_frame drops iFrame_valid together with iLine_valid
  task automatic send_line(input int n, input line_t px, input bit end_frame);
    iLine_valid = 1'b1;
    tick(1);
    for (int i = 0; i < n; i++) begin
      iData = px[i];
      iData_valid = 1'b1;
      acc[i] = cyc;
      tick(1);
    end
    iData_valid = 1'b0;
    iLine_valid = 1'b0;
    if (end_frame) begin
      iFrame_valid = 1'b0;
      exp_frames++;
    end
    tick(3);
  endtask

  task automatic expect_px(input int r, input int g, input int b, input int c);
    exp_q.push_back('{r, g, b, c});
  endtask

  task automatic check_outputs(input string name);
    check({name, "_count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      check({name, "_red"},   act_q[i].r,   exp_q[i].r);
      check({name, "_green"}, act_q[i].g,   exp_q[i].g);
      check({name, "_blue"},  act_q[i].b,   exp_q[i].b);
      check({name, "_cycle"}, act_q[i].cyc, exp_q[i].cyc);
    end
    act_q.delete();
    exp_q.delete();
  endtask

  function automatic int exp_fc();
`ifdef DEMOSAIC_FRAME_COUNT_EN
    return exp_frames;
`else
    return 0;
`endif
  endfunction

  initial begin
    vecs[0] = '{100,  200,  300,  110,  200,  105, 300};
    vecs[1] = '{1023, 1023, 0,    1022, 1023, 1022, 0};
    vecs[2] = '{0,    5,    7,    1,    5,    0,    7};
    vecs[3] = '{1,    1000, 999,  0,    1000, 0,    999};
    vecs[4] = '{512,  0,    1023, 513,  0,    512,  1023};
    vecs[5] = '{1023, 1,    2,    1023, 1,    1023, 2};

    Resetn = 1'b0; Enable = 1'b0; iData = 10'd0;
    iData_valid = 1'b0; iFrame_valid = 1'b0; iLine_valid = 1'b0;
    tick(3);
    check("reset_valid", oData_valid, 0);
    check("reset_red", oRed, 0);
    check("reset_green", oGreen, 0);
    check("reset_blue", oBlue, 0);
    check("reset_frames", oFrame_count, 0);
    Resetn = 1'b1;
    Enable = 1'b1;
    tick(2);

    // single-quad frames from the table
    for (int v = 0; v < 6; v++) begin
      frame_begin();
      send_line(2, mk6(vecs[v].g1, vecs[v].r), 1'b0);
      send_line(2, mk6(vecs[v].b, vecs[v].g2), 1'b1);
      expect_px(vecs[v].er, vecs[v].eg, vecs[v].eb, acc[1] + 2);
      check_outputs("vec");
    end

    // 4x2 frame: two pixels, each two cycles after its G2
    frame_begin();
    send_line(4, mk6(100, 200, 102, 202), 1'b0);
    send_line(4, mk6(300, 110, 302, 112), 1'b1);
    expect_px(200, 105, 300, acc[1] + 2);
    expect_px(202, 107, 302, acc[3] + 2);
    check_outputs("quad4x2");

    // short even row limits the odd row
    frame_begin();
    send_line(2, mk6(10, 20), 1'b0);
    send_line(6, mk6(30, 40, 50, 60, 70, 80), 1'b1);
    expect_px(20, 25, 30, acc[1] + 2);
    check_outputs("short_even");

    // odd line length over two row pairs
    frame_begin();
    send_line(5, mk6(1, 2, 3, 4, 5), 1'b0);
    send_line(5, mk6(6, 8, 10, 12, 14), 1'b0);
    expect_px(2, 4, 6, acc[1] + 2);
    expect_px(4, 7, 10, acc[3] + 2);
    send_line(5, mk6(20, 40, 60, 80, 100), 1'b0);
    send_line(5, mk6(30, 50, 70, 90, 110), 1'b1);
    expect_px(40, 35, 30, acc[1] + 2);
    expect_px(80, 75, 70, acc[3] + 2);
    check_outputs("five_px");

    // lines longer than the 8-entry buffer: columns 8 and 9 ignored
    frame_begin();
    for (int k = 0; k < 16; k++) ln[k] = 10'(k * 10);
    send_line(10, ln, 1'b0);
    for (int k = 0; k < 16; k++) ln[k] = 10'(100 + k);
    send_line(10, ln, 1'b1);
    expect_px(10, 50, 100, acc[1] + 2);
    expect_px(30, 61, 102, acc[3] + 2);
    expect_px(50, 72, 104, acc[5] + 2);
    expect_px(70, 83, 106, acc[7] + 2);
    check_outputs("saturate");

    // frame ends after an even row; then an empty line must not flip parity
    frame_begin();
    send_line(2, mk6(1, 2), 1'b1);
    check_outputs("even_only");
    frame_begin();
    send_line(2, mk6(100, 200), 1'b0);
    iLine_valid = 1'b1;
    tick(2);
    iLine_valid = 1'b0;
    tick(2);
    send_line(2, mk6(300, 110), 1'b1);
    expect_px(200, 105, 300, acc[1] + 2);
    check_outputs("empty_line");
    check("frames_mid", oFrame_count, exp_fc());

    // Enable dropped mid-frame
    frame_begin();
    send_line(2, mk6(5, 6), 1'b0);
    send_line(2, mk6(7, 8), 1'b0);
    expect_px(6, 6, 7, acc[1] + 2);
    Enable = 1'b0;
    tick(2);
    send_line(2, mk6(9, 9), 1'b0);
    send_line(2, mk6(9, 9), 1'b0);
    iFrame_valid = 1'b0;
    tick(3);
    check_outputs("enable_drop");
    check("frames_after_abort", oFrame_count, exp_fc());
    Enable = 1'b1;
    tick(2);
    frame_begin();
    send_line(2, mk6(11, 12), 1'b0);
    send_line(2, mk6(13, 14), 1'b1);
    expect_px(12, 12, 13, acc[1] + 2);
    check_outputs("recover");
    check("frames_recover", oFrame_count, exp_fc());

    // reset in the middle of a frame, frame level still high on release
    frame_begin();
    send_line(2, mk6(40, 50), 1'b0);
    send_line(2, mk6(60, 70), 1'b0);
    Resetn = 1'b0;
    tick(1);
    check("midreset_valid", oData_valid, 0);
    check("midreset_red", oRed, 0);
    check("midreset_frames", oFrame_count, 0);
    act_q.delete();
    exp_frames = 0;
    Resetn = 1'b1;
    tick(2);
    send_line(2, mk6(1, 1), 1'b0);
    send_line(2, mk6(1, 1), 1'b0);
    iFrame_valid = 1'b0;
    tick(3);
    check_outputs("after_reset");
    check("frames_after_reset", oFrame_count, 0);
    frame_begin();
    send_line(2, mk6(2, 4), 1'b0);
    send_line(2, mk6(6, 8), 1'b1);
    expect_px(4, 5, 6, acc[1] + 2);
    check_outputs("post_reset_frame");
    check("frames_final", oFrame_count, exp_fc());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
